// File: rtl/ov7670_cfg_sequencer.sv
// OV7670 register-init sequencer feeding an SCCB master.
// Walks a {addr,val} ROM with delay entries, NACK retry and done/error status.
module ov7670_cfg_sequencer #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int DELAY_MS   = 10,
  parameter int ROM_DEPTH  = 64,
  parameter int MAX_RETRY  = 3,
  parameter int AUTO_START = 1,
  localparam int IW = $clog2(ROM_DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_cfg_start,
  output logic          o_cfg_busy,
  output logic          o_cfg_done,
  output logic          o_cfg_err,
  output logic [IW-1:0] o_index,
  output logic          o_sccb_start,
  output logic [7:0]    o_sccb_addr,
  output logic [7:0]    o_sccb_din,
  input  logic          i_sccb_ready,
  input  logic          i_sccb_done,
  input  logic          i_sccb_ack
);

  localparam int DELAY_CYCLES = CLK_FREQ / 1000 * DELAY_MS;
  localparam int DC = (DELAY_CYCLES < 1) ? 1 : DELAY_CYCLES;
  localparam int DW = $clog2(DC + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_ACCEPT,
    S_WAIT_DONE,
    S_WAIT_READY,
    S_DELAY,
    S_DONE,
    S_ERROR
  } state_t;

  state_t          state;
  state_t          nxt;
  logic [IW-1:0]   index;
  logic [RW-1:0]   retry;
  logic [DW-1:0]   dcnt;
  logic [7:0]      addr;
  logic [7:0]      din;
  logic            auto_pend;
  logic [15:0]     rom_q;
  logic            is_end;
  logic            is_delay;
  logic            last_dly;
  logic            retry_max;
  logic            go;

  // 16'hFFFF ends the table, 16'hFFF0 inserts a settle delay
  always_comb begin
    rom_q = 16'hFFFF;
    case (int'(index))
      0:  rom_q = 16'h1280;
      1:  rom_q = 16'hFFF0;
      2:  rom_q = 16'h1204;
      3:  rom_q = 16'h1100;
      4:  rom_q = 16'h0C00;
      5:  rom_q = 16'h3E00;
      6:  rom_q = 16'h8C00;
      7:  rom_q = 16'h0400;
      8:  rom_q = 16'h40D0;
      9:  rom_q = 16'h3A04;
      10: rom_q = 16'h1418;
      11: rom_q = 16'h4FB3;
      12: rom_q = 16'h50B3;
      13: rom_q = 16'h5100;
      14: rom_q = 16'h523D;
      15: rom_q = 16'h53A7;
      16: rom_q = 16'h54E4;
      17: rom_q = 16'h589E;
      18: rom_q = 16'h3DC0;
      19: rom_q = 16'h1714;
      20: rom_q = 16'h1802;
      default: rom_q = 16'hFFFF;
    endcase
  end

  assign is_end    = (rom_q == 16'hFFFF) ||
                     (index == IW'(ROM_DEPTH - 1));
  assign is_delay  = (rom_q == 16'hFFF0);
  assign last_dly  = (dcnt == DW'(DC - 1));
  assign retry_max = (retry == RW'(MAX_RETRY));
  assign go        = i_cfg_start | auto_pend;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= S_IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR:
        if (go) nxt = S_FETCH;
      S_FETCH:
        if (is_end)        nxt = S_DONE;
        else if (is_delay) nxt = S_DELAY;
        else               nxt = S_ISSUE;
      S_ISSUE:
        if (i_sccb_ready) nxt = S_WAIT_ACCEPT;
      S_WAIT_ACCEPT:
        if (!i_sccb_ready) nxt = S_WAIT_DONE;
      S_WAIT_DONE:
        if (i_sccb_done) begin
          if (i_sccb_ack)     nxt = S_WAIT_READY;
          else if (retry_max) nxt = S_ERROR;
          else                nxt = S_ISSUE;
        end
      S_WAIT_READY:
        if (i_sccb_ready) nxt = S_FETCH;
      S_DELAY:
        if (last_dly) nxt = S_FETCH;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      index     <= '0;
      retry     <= '0;
      dcnt      <= '0;
      addr      <= '0;
      din       <= '0;
      auto_pend <= (AUTO_START != 0);
    end else begin
      auto_pend <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR:
          if (go) begin
            index <= '0;
            retry <= '0;
          end
        S_FETCH:
          if (!is_end) begin
            if (is_delay) begin
              dcnt <= '0;
            end else begin
              addr <= rom_q[15:8];
              din  <= rom_q[7:0];
            end
          end
        S_WAIT_DONE:
          if (i_sccb_done) begin
            if (i_sccb_ack) begin
              retry <= '0;
              index <= index + 1'b1;
            end else if (!retry_max) begin
              retry <= retry + 1'b1;
            end
          end
        S_DELAY:
          if (last_dly) index <= index + 1'b1;
          else          dcnt  <= dcnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    o_cfg_busy   = 1'b1;
    o_cfg_done   = 1'b0;
    o_cfg_err    = 1'b0;
    o_sccb_start = 1'b0;
    unique case (state)
      S_IDLE:        o_cfg_busy = 1'b0;
      S_DONE: begin
        o_cfg_busy = 1'b0;
        o_cfg_done = 1'b1;
      end
      S_ERROR: begin
        o_cfg_busy = 1'b0;
        o_cfg_err  = 1'b1;
      end
      S_WAIT_ACCEPT: o_sccb_start = 1'b1;
      default: ;
    endcase
  end

  assign o_index     = index;
  assign o_sccb_addr = addr;
  assign o_sccb_din  = din;

endmodule

// File: tb/tb_ov7670_cfg_sequencer.sv
// Bench for ov7670_cfg_sequencer with a behavioural SCCB master
// and a list-walking reference model of the expected write stream.
module tb_ov7670_cfg_sequencer;

  localparam int MAX_RETRY = 3;
  localparam int DC        = 10;
  localparam int ROM_DEPTH = 64;
  localparam int N_ROM     = 22;

  localparam logic [15:0] ROMV [0:N_ROM-1] = '{
    16'h1280, 16'hFFF0, 16'h1204, 16'h1100, 16'h0C00, 16'h3E00,
    16'h8C00, 16'h0400, 16'h40D0, 16'h3A04, 16'h1418, 16'h4FB3,
    16'h50B3, 16'h5100, 16'h523D, 16'h53A7, 16'h54E4, 16'h589E,
    16'h3DC0, 16'h1714, 16'h1802, 16'hFFFF
  };

  typedef struct packed {
    logic [15:0] idx;
    logic [7:0]  addr;
    logic [7:0]  din;
  } log_t;

  typedef struct {
    string nm;
    int    ent;
    int    nacks;
    bit    done;
    bit    err;
    int    idx;
    int    nst;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       cfg_start;
  logic       cfg_busy;
  logic       cfg_done;
  logic       cfg_err;
  logic [5:0] index;
  logic       sccb_start;
  logic [7:0] sccb_addr;
  logic [7:0] sccb_din;
  logic       m_ready;
  logic       m_done;
  logic       m_ack;

  int   vectors = 0;
  int   miscompares = 0;
  int   plan [ROM_DEPTH];
  log_t act [$];
  log_t exp_q [$];
  bit   exp_err;
  int   exp_idx;
  int   n_starts = 0;
  int   viol = 0;
  logic prev_start = 1'b0;
  log_t cur;

  logic m_busy;
  logic m_ack_pl;
  int   m_cnt;
  int   m_att;
  int   m_last;

  ov7670_cfg_sequencer #(
    .CLK_FREQ  (1000),
    .DELAY_MS  (10),
    .ROM_DEPTH (ROM_DEPTH),
    .MAX_RETRY (MAX_RETRY),
    .AUTO_START(1)
  ) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_cfg_start (cfg_start),
    .o_cfg_busy  (cfg_busy),
    .o_cfg_done  (cfg_done),
    .o_cfg_err   (cfg_err),
    .o_index     (index),
    .o_sccb_start(sccb_start),
    .o_sccb_addr (sccb_addr),
    .o_sccb_din  (sccb_din),
    .i_sccb_ready(m_ready),
    .i_sccb_done (m_done),
    .i_sccb_ack  (m_ack)
  );

  always #5 clk = ~clk;

  // SCCB master: ready drops 2 cycles after start, done 20 cycles later
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_ready  <= 1'b1;
      m_done   <= 1'b0;
      m_ack    <= 1'b0;
      m_busy   <= 1'b0;
      m_ack_pl <= 1'b0;
      m_cnt    <= 0;
      m_att    <= 0;
      m_last   <= -1;
    end else begin
      m_done <= 1'b0;
      if (cfg_start) begin
        m_att  <= 0;
        m_last <= -1;
      end
      if (!m_busy) begin
        if (sccb_start && m_ready) begin
          m_busy <= 1'b1;
          m_cnt  <= 0;
          m_last <= int'(index);
          if (int'(index) != m_last) begin
            m_ack_pl <= (plan[index] == 0);
            m_att    <= 1;
          end else begin
            m_ack_pl <= (m_att >= plan[index]);
            m_att    <= m_att + 1;
          end
        end
      end else begin
        m_cnt <= m_cnt + 1;
        if (m_cnt == 0) m_ready <= 1'b0;
        if (m_cnt == 20) begin
          m_done  <= 1'b1;
          m_ack   <= m_ack_pl;
          m_ready <= 1'b1;
          m_busy  <= 1'b0;
        end
      end
    end
  end

  // log every write request and flag overlap or unstable fields
  always @(negedge clk) begin
    if (sccb_start && !prev_start) begin
      act.push_back(log_t'{16'(index), sccb_addr, sccb_din});
      cur      <= log_t'{16'(index), sccb_addr, sccb_din};
      n_starts <= n_starts + 1;
      if (m_busy) viol <= viol + 1;
    end else if (sccb_start) begin
      if (sccb_addr != cur.addr || sccb_din != cur.din ||
          16'(index) != cur.idx)
        viol <= viol + 1;
    end
    prev_start <= sccb_start;
  end

  function automatic logic [15:0] rom_ref(input int i);
    if (i < N_ROM) return ROMV[i];
    return 16'hFFFF;
  endfunction

  task automatic chk(input string nm, input longint a,
                     input longint e);
    vectors++;
    if (a != e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic model();
    int i;
    int tries;
    logic [15:0] e;
    i = 0;
    exp_q.delete();
    exp_err = 1'b0;
    exp_idx = 0;
    while (1) begin
      e = rom_ref(i);
      if (e == 16'hFFFF || i == ROM_DEPTH - 1) begin
        exp_idx = i;
        break;
      end
      if (e == 16'hFFF0) begin
        i++;
        continue;
      end
      tries = (plan[i] > MAX_RETRY) ? MAX_RETRY + 1 : plan[i] + 1;
      repeat (tries) exp_q.push_back(log_t'{16'(i), e[15:8], e[7:0]});
      if (plan[i] > MAX_RETRY) begin
        exp_err = 1'b1;
        exp_idx = i;
        break;
      end
      i++;
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, " busy"}, cfg_busy, 0);
    chk({nm, " done"}, cfg_done, 0);
    chk({nm, " err"}, cfg_err, 0);
    chk({nm, " start"}, sccb_start, 0);
    chk({nm, " index"}, index, 0);
    chk({nm, " addr"}, sccb_addr, 0);
    chk({nm, " din"}, sccb_din, 0);
  endtask

  task automatic wait_idle(input string nm);
    int c;
    c = 0;
    while (cfg_busy && c < 5000) begin
      @(negedge clk);
      c++;
    end
    chk({nm, " idle timeout"}, cfg_busy, 0);
  endtask

  task automatic wait_starts(input string nm, input int target);
    int c;
    c = 0;
    while (n_starts < target && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk({nm, " start timeout"}, n_starts >= target, 1);
  endtask

  task automatic pulse_start(input string nm);
    @(negedge clk);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    chk({nm, " restart busy"}, cfg_busy, 1);
    chk({nm, " restart done"}, cfg_done, 0);
    chk({nm, " restart err"}, cfg_err, 0);
  endtask

  task automatic compare_run(input string nm, input int base);
    model();
    chk({nm, " starts"}, n_starts - base, exp_q.size());
    for (int k = 0; k < exp_q.size() && base + k < act.size(); k++)
      chk({nm, $sformatf(" write%0d", k)}, act[base+k], exp_q[k]);
    chk({nm, " done"}, cfg_done, !exp_err);
    chk({nm, " err"}, cfg_err, exp_err);
    chk({nm, " index"}, index, exp_idx);
    chk({nm, " start low"}, sccb_start, 0);
    chk({nm, " protocol"}, viol, 0);
  endtask

  task automatic clear_plan();
    for (int i = 0; i < ROM_DEPTH; i++) plan[i] = 0;
  endtask

  initial begin
    vec_t tbl [7];
    int base;
    int cnt;
    int s0;
    int snap;

    tbl[0] = '{"ack_all",   2,  0, 1, 0, 21, 20};
    tbl[1] = '{"nack2_x2",  2,  2, 1, 0, 21, 22};
    tbl[2] = '{"nack2_x4",  2,  4, 0, 1, 2,  5};
    tbl[3] = '{"nack0_x3",  0,  3, 1, 0, 21, 23};
    tbl[4] = '{"nack0_x4",  0,  4, 0, 1, 0,  4};
    tbl[5] = '{"nack20_x4", 20, 4, 0, 1, 20, 23};
    tbl[6] = '{"nack9_x1",  9,  1, 1, 0, 21, 21};

    clear_plan();
    rstn = 1'b0;
    cfg_start = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");

    // auto start: COM7 reset, then a delay with no traffic, then entry 2
    base = n_starts;
    rstn = 1'b1;
    wait_starts("auto", base + 1);
    chk("auto first write", act[base], log_t'{16'd0, 8'h12, 8'h80});
    cnt = 0;
    while (index == 6'd0 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    s0 = n_starts;
    cnt = 0;
    while (index == 6'd1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    // one WAIT_READY cycle and one FETCH cycle bracket the delay
    chk("delay window", cnt, DC + 2);
    chk("delay no start", n_starts, s0);
    wait_starts("auto", base + 2);
    chk("after delay write", act[base+1], log_t'{16'd2, 8'h12, 8'h04});
    wait_idle("auto");
    compare_run("auto", base);

    foreach (tbl[r]) begin
      clear_plan();
      plan[tbl[r].ent] = tbl[r].nacks;
      base = n_starts;
      pulse_start(tbl[r].nm);
      wait_idle(tbl[r].nm);
      chk({tbl[r].nm, " tbl starts"}, n_starts - base, tbl[r].nst);
      chk({tbl[r].nm, " tbl done"}, cfg_done, tbl[r].done);
      chk({tbl[r].nm, " tbl err"}, cfg_err, tbl[r].err);
      chk({tbl[r].nm, " tbl index"}, index, tbl[r].idx);
      compare_run(tbl[r].nm, base);
    end

    // start while busy is ignored; start in DONE reruns
    clear_plan();
    base = n_starts;
    pulse_start("busy_start");
    wait_starts("busy_start", base + 4);
    cnt = 0;
    while (sccb_start && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    snap = int'(index);
    @(negedge clk);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    chk("busy_start index", index, snap);
    chk("busy_start busy", cfg_busy, 1);
    wait_idle("busy_start");
    compare_run("busy_start", base);
    base = n_starts;
    pulse_start("done_rerun");
    wait_idle("done_rerun");
    compare_run("done_rerun", base);

    // asynchronous reset in the middle of a write
    base = n_starts;
    pulse_start("midreset");
    wait_starts("midreset", base + 3);
    cnt = 0;
    while (sccb_start && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1 check_zero("midreset");
    repeat (2) @(negedge clk);
    base = n_starts;
    rstn = 1'b1;
    wait_starts("midreset", base + 1);
    chk("midreset first write", act[base], log_t'{16'd0, 8'h12, 8'h80});
    wait_idle("midreset");
    compare_run("midreset", base);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < ROM_DEPTH; i++) begin
        int v;
        v = $urandom_range(0, 9);
        if (v < 6)       plan[i] = 0;
        else if (v < 8)  plan[i] = 1;
        else if (v == 8) plan[i] = 2;
        else             plan[i] = $urandom_range(3, 5);
      end
      base = n_starts;
      pulse_start($sformatf("rand%0d", r));
      wait_idle($sformatf("rand%0d", r));
      compare_run($sformatf("rand%0d", r), base);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
